add_sub_vec: RTL and testbench

//   Parametrised streaming lane-wise integer add/sub engine with ap_ctrl_hs-style

---
 rtl/add_sub_vec.sv | 167 ++++++++++++++++
 tb/tb_add_sub_vec.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_vec.sv
// Streaming lane-wise add/sub kernel with ap_ctrl_hs control, joined AXI-Stream
// inputs, optional signed saturation and a 2-entry output buffer.
module add_sub_vec #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_idle,
    output logic                    ap_ready,
    input  logic [1:0]              op,
    input  logic [CNT_W-1:0]        num_beats,
    input  logic [LANES*LANE_W-1:0] axis_in1_TDATA,
    input  logic                    axis_in1_TVALID,
    output logic                    axis_in1_TREADY,
    input  logic [LANES*LANE_W-1:0] axis_in2_TDATA,
    input  logic                    axis_in2_TVALID,
    output logic                    axis_in2_TREADY,
    output logic [LANES*LANE_W-1:0] axis_out_TDATA,
    output logic                    axis_out_TVALID,
    input  logic                    axis_out_TREADY,
    output logic                    axis_out_TLAST,
    output logic [CNT_W-1:0]        sat_cnt
);

    localparam int DATA_W = LANES * LANE_W;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic [CNT_W-1:0] nb_q;
    logic [CNT_W-1:0] in_cnt;

    logic [DATA_W-1:0] mem_data [2];
    logic [1:0]        mem_last;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        occ;

    logic              accept;
    logic              pop;
    logic              room;
    logic              last_in;
    logic [DATA_W-1:0] res;
    logic              clip;
    logic [LANE_W:0]   ax, bx, sx;

    // Lane arithmetic is done one bit wider so signed overflow shows up
    // as a mismatch between the two top bits.
    always_comb begin
        res  = '0;
        clip = 1'b0;
        ax   = '0;
        bx   = '0;
        sx   = '0;
        for (int i = 0; i < LANES; i++) begin
            ax = {axis_in1_TDATA[i*LANE_W+LANE_W-1],
                  axis_in1_TDATA[i*LANE_W +: LANE_W]};
            bx = {axis_in2_TDATA[i*LANE_W+LANE_W-1],
                  axis_in2_TDATA[i*LANE_W +: LANE_W]};
            sx = op_q[0] ? (ax - bx) : (ax + bx);
            if (op_q[1] && (sx[LANE_W] != sx[LANE_W-1])) begin
                clip = 1'b1;
                res[i*LANE_W +: LANE_W] = sx[LANE_W] ? SMIN : SMAX;
            end else begin
                res[i*LANE_W +: LANE_W] = sx[LANE_W-1:0];
            end
        end
    end

    assign pop     = axis_out_TVALID & axis_out_TREADY;
    assign room    = (occ != 2'd2) | pop;
    assign accept  = (state == S_RUN) & axis_in1_TVALID & axis_in2_TVALID
                   & room & (in_cnt < nb_q);
    assign last_in = (in_cnt == (nb_q - CNT_ONE));

    assign axis_in1_TREADY = accept;
    assign axis_in2_TREADY = accept;

    assign axis_out_TVALID = (occ != 2'd0);
    assign axis_out_TDATA  = mem_data[rd_ptr];
    assign axis_out_TLAST  = mem_last[rd_ptr] & axis_out_TVALID;

    assign ap_idle  = (state == S_IDLE);
    assign ap_done  = (state == S_DONE);
    assign ap_ready = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (ap_start) begin
                    state_nxt = (num_beats == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (pop && axis_out_TLAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            nb_q    <= '0;
            in_cnt  <= '0;
            sat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && ap_start) begin
                op_q    <= op;
                nb_q    <= num_beats;
                in_cnt  <= '0;
                sat_cnt <= '0;
            end else if (accept) begin
                in_cnt <= in_cnt + CNT_ONE;
                if (clip && (sat_cnt != '1)) begin
                    sat_cnt <= sat_cnt + CNT_ONE;
                end
            end
        end
    end

    // Two-slot ring; a full buffer may push and pop on the same edge.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (accept) begin
                mem_data[wr_ptr] <= res;
                mem_last[wr_ptr] <= last_in;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({accept, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_vec.sv
// Directed bench for add_sub_vec: single-beat vector table plus
// multi-beat, back-pressure, join, empty-run and reset sequences.
module tb_add_sub_vec;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int CNT_W  = 16;
    localparam int DW     = LANES * LANE_W;

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic             ap_start;
    logic             ap_done;
    logic             ap_idle;
    logic             ap_ready;
    logic [1:0]       op;
    logic [CNT_W-1:0] num_beats;
    logic [DW-1:0]    axis_in1_TDATA;
    logic             axis_in1_TVALID;
    logic             axis_in1_TREADY;
    logic [DW-1:0]    axis_in2_TDATA;
    logic             axis_in2_TVALID;
    logic             axis_in2_TREADY;
    logic [DW-1:0]    axis_out_TDATA;
    logic             axis_out_TVALID;
    logic             axis_out_TREADY;
    logic             axis_out_TLAST;
    logic [CNT_W-1:0] sat_cnt;

    add_sub_vec #(
        .LANES (LANES),
        .LANE_W(LANE_W),
        .CNT_W (CNT_W)
    ) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .ap_ready       (ap_ready),
        .op             (op),
        .num_beats      (num_beats),
        .axis_in1_TDATA (axis_in1_TDATA),
        .axis_in1_TVALID(axis_in1_TVALID),
        .axis_in1_TREADY(axis_in1_TREADY),
        .axis_in2_TDATA (axis_in2_TDATA),
        .axis_in2_TVALID(axis_in2_TVALID),
        .axis_in2_TREADY(axis_in2_TREADY),
        .axis_out_TDATA (axis_out_TDATA),
        .axis_out_TVALID(axis_out_TVALID),
        .axis_out_TREADY(axis_out_TREADY),
        .axis_out_TLAST (axis_out_TLAST),
        .sat_cnt        (sat_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic [DW-1:0] qe[$];

    int r_done_cyc;
    int r_first_acc;
    int r_first_vld;
    int r_max_inf;
    bit r_dropped;
    bit r_lone_bad;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] y;
        int            sat;
    } vec_t;

    vec_t vt[8];

    function automatic logic [DW-1:0] pack(input logic [31:0] l3, l2, l1, l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] y);
        q1.push_back(a);
        q2.push_back(b);
        qe.push_back(y);
    endtask

    task automatic clear_q();
        q1.delete();
        q2.delete();
        qe.delete();
    endtask

    // Start a run and stream q1/q2 in, checking every output beat against qe.
    task automatic run_stream(input logic [1:0] op_i, input int nb,
                              input int stall_from, input int stall_len,
                              input int in2_delay, input string tag);
        int ii;
        int oi;
        int last_pop;
        int inf;
        ii = 0;
        oi = 0;
        last_pop = -1;
        r_done_cyc = -1;
        r_first_acc = -1;
        r_first_vld = -1;
        r_max_inf = 0;
        r_dropped = 0;
        r_lone_bad = 0;
        @(negedge ap_clk);
        ap_start  = 1'b1;
        op        = op_i;
        num_beats = CNT_W'(nb);
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge ap_clk);
            if (cyc == 0) begin
                ap_start  = 1'b0;
                op        = ~op_i;
                num_beats = CNT_W'(nb + 3);
            end
            axis_in1_TVALID = (ii < nb);
            axis_in2_TVALID = (ii < nb) && (cyc >= in2_delay);
            axis_in1_TDATA  = (ii < nb) ? q1[ii] : '0;
            axis_in2_TDATA  = (ii < nb) ? q2[ii] : '0;
            axis_out_TREADY = !(cyc >= stall_from && cyc < stall_from + stall_len);
            #1;
            if (ap_done) begin
                r_done_cyc = cyc;
                break;
            end
            if (axis_out_TVALID && r_first_vld < 0) r_first_vld = cyc;
            if (axis_in1_TVALID && !axis_in2_TVALID &&
                (axis_in1_TREADY || axis_in2_TREADY)) r_lone_bad = 1;
            if (axis_in1_TREADY != axis_in2_TREADY) r_lone_bad = 1;
            if (axis_in1_TVALID && axis_in2_TVALID && !axis_in1_TREADY)
                r_dropped = 1;
            if (axis_out_TVALID && axis_out_TREADY) begin
                if (oi < nb) begin
                    chk($sformatf("%s_data%0d", tag, oi), axis_out_TDATA, qe[oi]);
                    chki($sformatf("%s_last%0d", tag, oi),
                         int'(axis_out_TLAST), int'(oi == nb - 1));
                end
                if (axis_out_TLAST) last_pop = cyc;
                oi++;
            end
            if (axis_in1_TREADY && axis_in2_TREADY) begin
                if (r_first_acc < 0) r_first_acc = cyc;
                ii++;
            end
            inf = ii - oi;
            if (inf > r_max_inf) r_max_inf = inf;
        end
        axis_in1_TVALID = 1'b0;
        axis_in2_TVALID = 1'b0;
        axis_out_TREADY = 1'b1;
        chki({tag, "_done_seen"}, int'(r_done_cyc >= 0), 1);
        chki({tag, "_ready"}, int'(ap_ready), 1);
        chki({tag, "_beats_in"}, ii, nb);
        chki({tag, "_beats_out"}, oi, nb);
        if (nb > 0) chki({tag, "_done_lat"}, r_done_cyc - last_pop, 1);
        @(negedge ap_clk);
        #1;
        chki({tag, "_done_pulse"}, int'({ap_done, ap_idle}), 1);
    endtask

    initial begin
        bit seen_done;

        vt[0] = '{2'b00, pack(4, 3, 2, 1), pack(1, 1, 1, 1), pack(5, 4, 3, 2), 0};
        vt[1] = '{2'b01, pack(10, 20, 30, 0), pack(3, 25, 30, 1),
                  pack(7, 32'hFFFFFFFB, 0, 32'hFFFFFFFF), 0};
        vt[2] = '{2'b00, pack(32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF),
                  pack(1, 1, 32'h80000000, 1), pack(0, 32'h80000000, 0, 0), 0};
        vt[3] = '{2'b10, pack(32'h7FFFFFFF, 5, 32'h80000000, 32'h7FFFFFFF),
                  pack(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1),
                  pack(32'h7FFFFFFF, 4, 32'h80000000, 32'h7FFFFFFF), 1};
        vt[4] = '{2'b11, pack(32'h80000000, 10, 32'h7FFFFFFF, 32'h80000000),
                  pack(1, 3, 32'hFFFFFFFF, 1),
                  pack(32'h80000000, 7, 32'h7FFFFFFF, 32'h80000000), 1};
        vt[5] = '{2'b10, pack(100, 32'hFFFFFFFF, 50, 32'h7FFFFFFE),
                  pack(32'hFFFFFF9C, 32'hFFFFFFFF, 25, 1),
                  pack(0, 32'hFFFFFFFE, 32'h4B, 32'h7FFFFFFF), 0};
        vt[6] = '{2'b11, pack(0, 0, 5, 32'h80000000), pack(1, 32'hFFFFFFFF, 5, 0),
                  pack(32'hFFFFFFFF, 1, 0, 32'h80000000), 0};
        vt[7] = '{2'b11, pack(0, 0, 0, 32'h80000000), pack(0, 0, 0, 32'h7FFFFFFF),
                  pack(0, 0, 0, 32'h80000000), 1};

        ap_rst          = 1'b1;
        ap_start        = 1'b0;
        op              = 2'b00;
        num_beats       = '0;
        axis_in1_TDATA  = '0;
        axis_in1_TVALID = 1'b0;
        axis_in2_TDATA  = '0;
        axis_in2_TVALID = 1'b0;
        axis_out_TREADY = 1'b1;
        repeat (3) @(negedge ap_clk);
        #1;
        chki("rst_idle", int'(ap_idle), 1);
        chki("rst_done", int'({ap_done, ap_ready}), 0);
        chki("rst_tvalid", int'({axis_out_TVALID, axis_out_TLAST}), 0);
        chk("rst_tdata", axis_out_TDATA, '0);
        chki("rst_sat", int'(sat_cnt), 0);
        chki("rst_tready", int'({axis_in1_TREADY, axis_in2_TREADY}), 0);
        ap_rst = 1'b0;

        // T1: three identical add beats
        clear_q();
        repeat (3) load(pack(4, 3, 2, 1), pack(1, 1, 1, 1), pack(5, 4, 3, 2));
        run_stream(2'b00, 3, 1000, 0, 0, "t1");
        chki("t1_latency", r_first_vld - r_first_acc, 1);
        chki("t1_sat", int'(sat_cnt), 0);

        // single-beat vector table
        for (int k = 0; k < 8; k++) begin
            clear_q();
            load(vt[k].a, vt[k].b, vt[k].y);
            run_stream(vt[k].op, 1, 1000, 0, 0, $sformatf("vec%0d", k));
            chki($sformatf("vec%0d_sat", k), int'(sat_cnt), vt[k].sat);
        end

        // saturating run with two clipped beats out of three
        clear_q();
        load(pack(32'h7FFFFFFF, 0, 0, 0), pack(1, 0, 0, 0), pack(32'h7FFFFFFF, 0, 0, 0));
        load(pack(1, 2, 3, 4), pack(1, 1, 1, 1), pack(2, 3, 4, 5));
        load(pack(0, 0, 32'h80000000, 0), pack(0, 0, 32'h80000000, 0),
             pack(0, 0, 32'h80000000, 0));
        run_stream(2'b10, 3, 1000, 0, 0, "sat3");
        chki("sat3_cnt", int'(sat_cnt), 2);
        repeat (2) @(negedge ap_clk);
        chki("sat3_hold", int'(sat_cnt), 2);

        // T4: eight beats with output stalled for five cycles
        clear_q();
        for (int i = 0; i < 8; i++) begin
            load(pack(32'(i * 17), 32'(i + 100), 32'(i), 32'(i * 3)),
                 pack(1, 2, 3, 4),
                 pack(32'(i * 17 + 1), 32'(i + 102), 32'(i + 3), 32'(i * 3 + 4)));
        end
        run_stream(2'b00, 8, 1, 5, 0, "t4");
        chki("t4_max_buf", r_max_inf, 2);
        chki("t4_tready_drop", int'(r_dropped), 1);

        // T5: in2 withheld for four cycles, then an empty run
        clear_q();
        load(pack(9, 8, 7, 6), pack(1, 2, 3, 4), pack(8, 6, 4, 2));
        load(pack(0, 0, 0, 1), pack(0, 0, 0, 2), pack(0, 0, 0, 32'hFFFFFFFF));
        run_stream(2'b01, 2, 1000, 0, 4, "t5");
        chki("t5_no_lone", int'(r_lone_bad), 0);
        chki("t5_first_acc", r_first_acc, 4);
        clear_q();
        run_stream(2'b00, 0, 1000, 0, 0, "t5nb0");
        chki("t5nb0_done_cyc", r_done_cyc, 0);
        chki("t5nb0_no_valid", r_first_vld, -1);

        // T6: reset with two beats buffered
        @(negedge ap_clk);
        ap_start  = 1'b1;
        op        = 2'b10;
        num_beats = CNT_W'(8);
        @(negedge ap_clk);
        ap_start        = 1'b0;
        axis_in1_TDATA  = pack(32'h7FFFFFFF, 1, 1, 1);
        axis_in2_TDATA  = pack(1, 1, 1, 1);
        axis_in1_TVALID = 1'b1;
        axis_in2_TVALID = 1'b1;
        axis_out_TREADY = 1'b0;
        repeat (2) @(negedge ap_clk);
        #1;
        chki("t6_pre_valid", int'(axis_out_TVALID), 1);
        chki("t6_pre_full", int'(axis_in1_TREADY), 0);
        chki("t6_pre_sat", int'(sat_cnt), 2);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        #1;
        chki("t6_valid", int'(axis_out_TVALID), 0);
        chki("t6_idle", int'(ap_idle), 1);
        chki("t6_sat", int'(sat_cnt), 0);
        ap_rst          = 1'b0;
        axis_in1_TVALID = 1'b0;
        axis_in2_TVALID = 1'b0;
        axis_out_TREADY = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            #1;
            if (ap_done || axis_out_TVALID) seen_done = 1;
        end
        chki("t6_no_done", int'(seen_done), 0);

        // recovery after abort
        clear_q();
        load(pack(1, 1, 1, 1), pack(2, 2, 2, 2), pack(3, 3, 3, 3));
        run_stream(2'b00, 1, 1000, 0, 0, "t6rec");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
